// File: rtl/mips_instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder_pkg
//   Shared definitions for the MIPS instruction encoder:
//     - compact mnemonic codes accepted on cmd_mnem
//     - primary opcode and R-type funct constants
//     - the NOP word
//     - encoder FSM state encoding (IDLE / LOAD / FLUSH)
//     - small field-packing helpers for R, I and J formats
// -----------------------------------------------------------------------------
package mips_instr_encoder_pkg;

    // Mnemonic codes carried on cmd_mnem; 11..15 are illegal.
    typedef enum logic [3:0] {
        MN_NOP  = 4'd0,
        MN_ADD  = 4'd1,
        MN_SUB  = 4'd2,
        MN_AND  = 4'd3,
        MN_OR   = 4'd4,
        MN_SLT  = 4'd5,
        MN_LW   = 4'd6,
        MN_SW   = 4'd7,
        MN_BEQ  = 4'd8,
        MN_ADDI = 4'd9,
        MN_J    = 4'd10
    } mnem_e;

    // Primary opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction bits [5:0]).
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Encoder session FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // R-type: {op, rs, rt, rd, shamt=0, funct}
    function automatic logic [31:0] enc_r(input logic [4:0] rs,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd,
                                          input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b0_0000, funct};
    endfunction

    // I-type: {op, rs, rt, imm}
    function automatic logic [31:0] enc_i(input logic [5:0]  op,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // J-type: {op, word target}
    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// -----------------------------------------------------------------------------
// mips_instr_pack
//   Purely combinational packer: mnemonic + fields -> 32-bit MIPS word.
//   Anything that cannot be encoded (unknown mnemonic, or a BEQ whose
//   offset the caller flagged as unencodable) produces the NOP word and
//   raises o_illegal.
//
// Ports
//   i_mnem      [3:0]   mnemonic code (see mnem_e)
//   i_rs/rt/rd  [4:0]   register fields
//   i_imm       [15:0]  immediate for LW / SW / ADDI
//   i_beq_imm   [15:0]  already-resolved BEQ word offset
//   i_beq_bad           BEQ offset could not be encoded
//   i_target    [25:0]  J word target
//   o_word      [31:0]  encoded instruction
//   o_illegal           command could not be encoded; o_word is NOP
// -----------------------------------------------------------------------------
module mips_instr_pack
    import mips_instr_encoder_pkg::*;
(
    input  logic [3:0]  i_mnem,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [15:0] i_beq_imm,
    input  logic        i_beq_bad,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        o_word    = NOP_WORD;
        o_illegal = 1'b0;
        case (i_mnem)
            MN_NOP:  o_word = NOP_WORD;
            MN_ADD:  o_word = enc_r(i_rs, i_rt, i_rd, FN_ADD);
            MN_SUB:  o_word = enc_r(i_rs, i_rt, i_rd, FN_SUB);
            MN_AND:  o_word = enc_r(i_rs, i_rt, i_rd, FN_AND);
            MN_OR:   o_word = enc_r(i_rs, i_rt, i_rd, FN_OR);
            MN_SLT:  o_word = enc_r(i_rs, i_rt, i_rd, FN_SLT);
            MN_LW:   o_word = enc_i(OP_LW,   i_rs, i_rt, i_imm);
            MN_SW:   o_word = enc_i(OP_SW,   i_rs, i_rt, i_imm);
            MN_ADDI: o_word = enc_i(OP_ADDI, i_rs, i_rt, i_imm);
            MN_J:    o_word = enc_j(i_target);
            MN_BEQ: begin
                if (i_beq_bad) begin
                    o_illegal = 1'b1;
                end else begin
                    o_word = enc_i(OP_BEQ, i_rs, i_rt, i_beq_imm);
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
//   Packs compact instruction commands into 32-bit MIPS words and writes
//   them sequentially into instruction memory during a load session.
//   A session starts with `start` in IDLE at base_addr (word aligned),
//   accepts one command per cycle in LOAD, and ends with the command
//   flagged cmd_last; `done` pulses the cycle after the final write.
//
// Configuration macro
//   INSTR_ENC_ABS_BRANCH_EN  when defined, BEQ takes an absolute byte
//                            target on cmd_target and the encoder derives
//                            the signed word offset from the current pc.
//                            When undefined, BEQ uses cmd_imm verbatim.
//
// Ports
//   clk, reset_n           clock; synchronous active-low reset
//   start, base_addr       begin a session (honoured in IDLE only)
//   cmd_valid/cmd_ready    command handshake; ready only in LOAD
//   cmd_mnem, cmd_rs/rt/rd, cmd_imm, cmd_target, cmd_last
//                          command payload
//   imem_we/addr/wdata     instruction memory write port (registered)
//   busy                   session in progress (state != IDLE)
//   done                   one-cycle pulse after the last write
//   err                    sticky: illegal command, bad branch or pc wrap;
//                          cleared by the next start
// -----------------------------------------------------------------------------
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_mnem,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e             r_state;
    state_e             w_state_nxt;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_done;
    logic               r_err;

    logic               w_accept;
    logic               w_start_ok;
    logic [ADDR_W:0]    w_pc_sum;    // extra MSB is the wrap carry
    logic [15:0]        w_beq_imm;
    logic               w_beq_bad;
    logic [31:0]        w_word;
    logic               w_illegal;

    assign w_accept   = cmd_valid & cmd_ready;
    assign w_start_ok = (r_state == ST_IDLE) & start;
    assign w_pc_sum   = {1'b0, r_pc} + (ADDR_W + 1)'(4);

    // -------------------------------------------------------------------------
    // BEQ offset source
    // -------------------------------------------------------------------------
`ifdef INSTR_ENC_ABS_BRANCH_EN
    // Offset is relative to the delay-slot pc (pc+4) of this very command,
    // in words. It is encodable only if the target is word aligned and the
    // arithmetic-shifted difference fits a signed 16-bit field, i.e. all
    // bits from 15 upward agree.
    logic [ADDR_W-1:0] w_tgt_ext;
    logic [ADDR_W-1:0] w_diff;
    logic [ADDR_W-1:0] w_off;
    logic              w_in_range;

    assign w_tgt_ext  = ADDR_W'(cmd_target);
    assign w_diff     = w_tgt_ext - w_pc_sum[ADDR_W-1:0];
    assign w_off      = $signed(w_diff) >>> 2;
    assign w_in_range = (&w_off[ADDR_W-1:15]) | ~(|w_off[ADDR_W-1:15]);
    assign w_beq_imm  = w_off[15:0];
    assign w_beq_bad  = (cmd_target[1:0] != 2'b00) | ~w_in_range;
`else
    assign w_beq_imm  = cmd_imm;
    assign w_beq_bad  = 1'b0;
`endif

    mips_instr_pack u_pack (
        .i_mnem    (cmd_mnem),
        .i_rs      (cmd_rs),
        .i_rt      (cmd_rt),
        .i_rd      (cmd_rd),
        .i_imm     (cmd_imm),
        .i_beq_imm (w_beq_imm),
        .i_beq_bad (w_beq_bad),
        .i_target  (cmd_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples the values present before the edge.
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_accept && cmd_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state-decoded outputs (cmd_ready depends on state only)
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready = (r_state == ST_LOAD);
        busy      = (r_state != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // pc, write port and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Write strobe lives exactly one cycle after each accept.
            r_we   <= w_accept;
            // FLUSH is the cycle of the final write; done follows it.
            r_done <= (r_state == ST_FLUSH);

            if (w_start_ok) begin
                r_pc  <= base_addr & ~(ADDR_W'(3));
                r_err <= 1'b0;
            end else if (w_accept) begin
                r_pc    <= w_pc_sum[ADDR_W-1:0];
                r_addr  <= r_pc;
                r_wdata <= w_word;
                if (w_illegal || w_pc_sum[ADDR_W]) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_mips_instr_encoder
//   Directed self-checking bench for mips_instr_encoder. Inputs are driven
//   and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mips_instr_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_mnem;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic        cmd_last;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    mips_instr_encoder #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mnem   (cmd_mnem),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_rd     (cmd_rd),
        .cmd_imm    (cmd_imm),
        .cmd_target (cmd_target),
        .cmd_last   (cmd_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] m, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd,
                             input logic [15:0] imm, input logic [25:0] tgt,
                             input logic last);
        cmd_valid  = 1'b1;
        cmd_mnem   = m;
        cmd_rs     = rs;
        cmd_rt     = rt;
        cmd_rd     = rd;
        cmd_imm    = imm;
        cmd_target = tgt;
        cmd_last   = last;
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    task automatic begin_session(input logic [31:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, busy, done, err, cmd_ready} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_state: we=%b addr=%h data=%h busy=%b done=%b err=%b ready=%b, want all 0",
                     imem_we, imem_addr, imem_wdata, busy, done, err, cmd_ready);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, cmd_ready, imem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy/ready/we=%b, want 000", {busy, cmd_ready, imem_we});
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_add();
        begin_session(32'h0);
        n_checks++;
        if ({busy, cmd_ready, imem_we} !== 3'b110) begin
            n_fail++;
            $display("FAIL add_load_state: busy/ready/we=%b, want 110", {busy, cmd_ready, imem_we});
        end
        drive_cmd(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h0, 32'h0022_1820}) begin
            n_fail++;
            $display("FAIL add_write: we=%b addr=%h data=%h, want 1 00000000 00221820",
                     imem_we, imem_addr, imem_wdata);
        end
        n_checks++;
        if ({done, cmd_ready, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL add_flush: done/ready/busy=%b, want 001", {done, cmd_ready, busy});
        end
        tick();
        n_checks++;
        if ({done, imem_we, busy, err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL add_done: done/we/busy/err=%b, want 1000", {done, imem_we, busy, err});
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done_pulse: done=%b after one cycle, want 0", done);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        begin_session(32'h0);
        drive_cmd(4'd6, 5'd0, 5'd2, 5'd0, 16'h0008, 26'h0, 1'b0);
        tick();
        drive_cmd(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h0, 32'h8C02_0008}) begin
            n_fail++;
            $display("FAIL b2b_lw: we=%b addr=%h data=%h, want 1 00000000 8c020008",
                     imem_we, imem_addr, imem_wdata);
        end
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h4, 32'h0800_0010}) begin
            n_fail++;
            $display("FAIL b2b_j: we=%b addr=%h data=%h, want 1 00000004 08000010",
                     imem_we, imem_addr, imem_wdata);
        end
        tick();
        n_checks++;
        if ({imem_we, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_end: we/done=%b, want 01", {imem_we, done});
        end
        tick();
    endtask

    // -------------------------------------------------------------------------
    typedef struct {
        logic [3:0]  m;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    task automatic test_encodings();
        vec_t v [9];
        v[0] = '{4'd2,  5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       32'h0085_3022}; // SUB
        v[1] = '{4'd3,  5'd7,  5'd8,  5'd9,  16'h0000, 26'h0,       32'h00E8_4824}; // AND
        v[2] = '{4'd4,  5'd10, 5'd11, 5'd12, 16'h0000, 26'h0,       32'h014B_6025}; // OR
        v[3] = '{4'd5,  5'd13, 5'd14, 5'd15, 16'h0000, 26'h0,       32'h01AE_782A}; // SLT
        v[4] = '{4'd7,  5'd29, 5'd31, 5'd31, 16'hFFFC, 26'h0,       32'hAFBF_FFFC}; // SW
        v[5] = '{4'd9,  5'd1,  5'd1,  5'd7,  16'h8000, 26'h0,       32'h2021_8000}; // ADDI
        v[6] = '{4'd0,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0000_0000}; // NOP
        v[7] = '{4'd10, 5'd5,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFF_FFFF}; // J
        v[8] = '{4'd1,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0,       32'h03FF_F820}; // ADD
        begin_session(32'h0000_0203);   // low bits dropped -> 0x200
        for (int i = 0; i < 9; i++) begin
            drive_cmd(v[i].m, v[i].rs, v[i].rt, v[i].rd, v[i].imm, v[i].tgt, (i == 8));
            tick();
            n_checks++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h200 + 32'(4 * i), v[i].exp}) begin
                n_fail++;
                $display("FAIL enc_vec%0d: we=%b addr=%h data=%h, want 1 %h %h",
                         i, imem_we, imem_addr, imem_wdata, 32'h200 + 32'(4 * i), v[i].exp);
            end
        end
        idle_cmd();
        tick();
        n_checks++;
        if ({done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL enc_end: done/err=%b, want 10", {done, err});
        end
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_start_and_idle_valid();
        begin_session(32'h40);
        drive_cmd(4'd1, 5'd0, 5'd0, 5'd1, 16'h0, 26'h0, 1'b0);
        start     = 1'b1;           // must be ignored in LOAD
        base_addr = 32'h80;
        tick();
        start     = 1'b0;
        drive_cmd(4'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        n_checks++;
        if ({imem_addr, imem_wdata} !== {32'h40, 32'h0000_0820}) begin
            n_fail++;
            $display("FAIL start_ignored_w0: addr=%h data=%h, want 00000040 00000820", imem_addr, imem_wdata);
        end
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_addr, imem_wdata} !== {32'h44, 32'h0000_0025}) begin
            n_fail++;
            $display("FAIL start_ignored_w1: addr=%h data=%h, want 00000044 00000025", imem_addr, imem_wdata);
        end
        tick();
        tick();
        // cmd_valid while IDLE is not accepted
        drive_cmd(4'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b1);
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: cmd_ready=%b, want 0", cmd_ready);
        end
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_we, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_accept: we/busy=%b, want 00", {imem_we, busy});
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_illegal();
        begin_session(32'h0);
        drive_cmd(4'd13, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b1);
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, err} !== {1'b1, 32'h0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_write: we=%b addr=%h data=%h err=%b, want 1 00000000 00000000 1",
                     imem_we, imem_addr, imem_wdata, err);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if ({err, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal_sticky: err/busy=%b, want 10", {err, busy});
        end
        begin_session(32'h0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clear: err=%b after start, want 0", err);
        end
        drive_cmd(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        tick();
        idle_cmd();
        tick();
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_wrap();
        begin_session(32'hFFFF_FFFC);
        drive_cmd(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        tick();
        drive_cmd(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        n_checks++;
        if ({imem_we, imem_addr, err} !== {1'b1, 32'hFFFF_FFFC, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_w0: we=%b addr=%h err=%b, want 1 fffffffc 1", imem_we, imem_addr, err);
        end
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_we, imem_addr, err} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_w1: we=%b addr=%h err=%b, want 1 00000000 1", imem_we, imem_addr, err);
        end
        tick();
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_load();
        begin_session(32'h100);
        drive_cmd(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        drive_cmd(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        drive_cmd(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        reset_n = 1'b0;
        tick();
        n_checks++;
        if ({imem_we, busy, cmd_ready, done, imem_addr, imem_wdata} !== 68'd0) begin
            n_fail++;
            $display("FAIL midload_reset: we=%b busy=%b ready=%b done=%b addr=%h data=%h, want all 0",
                     imem_we, busy, cmd_ready, done, imem_addr, imem_wdata);
        end
        reset_n = 1'b1;
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_we, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midload_after: we/busy/done=%b, want 000", {imem_we, busy, done});
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_no_done: done=%b, want 0", done);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_beq();
`ifdef INSTR_ENC_ABS_BRANCH_EN
        begin_session(32'h0);
        for (int i = 0; i < 4; i++) begin
            drive_cmd(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
            tick();
        end
        drive_cmd(4'd8, 5'd1, 5'd2, 5'd0, 16'h7777, 26'h08, 1'b0);
        tick();
        n_checks++;
        if ({imem_addr, imem_wdata, err} !== {32'h10, 32'h1022_FFFD, 1'b0}) begin
            n_fail++;
            $display("FAIL beq_abs_back: addr=%h data=%h err=%b, want 00000010 1022fffd 0",
                     imem_addr, imem_wdata, err);
        end
        drive_cmd(4'd8, 5'd1, 5'd2, 5'd0, 16'h7777, 26'h20, 1'b0);
        tick();
        n_checks++;
        if ({imem_addr, imem_wdata, err} !== {32'h14, 32'h1022_0002, 1'b0}) begin
            n_fail++;
            $display("FAIL beq_abs_fwd: addr=%h data=%h err=%b, want 00000014 10220002 0",
                     imem_addr, imem_wdata, err);
        end
        drive_cmd(4'd8, 5'd1, 5'd2, 5'd0, 16'h7777, 26'h09, 1'b1);
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, err} !== {1'b1, 32'h18, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL beq_abs_misaligned: we=%b addr=%h data=%h err=%b, want 1 00000018 00000000 1",
                     imem_we, imem_addr, imem_wdata, err);
        end
`else
        begin_session(32'h0);
        drive_cmd(4'd8, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h09, 1'b1);
        tick();
        idle_cmd();
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, err} !== {1'b1, 32'h0, 32'h1022_1234, 1'b0}) begin
            n_fail++;
            $display("FAIL beq_imm: we=%b addr=%h data=%h err=%b, want 1 00000000 10221234 0",
                     imem_we, imem_addr, imem_wdata, err);
        end
`endif
        tick();
        tick();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        cmd_valid  = 1'b0;
        cmd_mnem   = '0;
        cmd_rs     = '0;
        cmd_rt     = '0;
        cmd_rd     = '0;
        cmd_imm    = '0;
        cmd_target = '0;
        cmd_last   = 1'b0;

        test_reset();
        test_single_add();
        test_back_to_back();
        test_encodings();
        test_start_and_idle_valid();
        test_illegal();
        test_wrap();
        test_reset_mid_load();
        test_beq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
